// File: rtl/cavlc_pkg.sv
// Shared CAVLC definitions: block limits, scan FSM states and the
// total-zeros table address packing used by Total_Zeros_Enc callers.
package cavlc_pkg;

    localparam int unsigned MAX_COEFF       = 16;
    localparam int unsigned COEFF_W_DEFAULT = 16;
    localparam int unsigned TZ_ADDR_W       = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    function automatic logic [TZ_ADDR_W-1:0] tz_addr_pack(
        input logic [3:0] tc,
        input logic [3:0] tz
    );
        return {tc, tz};
    endfunction

endpackage

// File: rtl/cavlc_coeff_classify.sv
// Combinational coefficient classifier: zero, +/-1 and sign flags.
module cavlc_coeff_classify #(
    parameter int unsigned COEFF_W = 16
) (
    input  logic [COEFF_W-1:0] coeff,
    output logic               is_zero,
    output logic               is_pm1,
    output logic               sign
);

    always_comb begin
        is_zero = (coeff == '0);
        is_pm1  = (coeff == COEFF_W'(1)) || (coeff == '1);
        sign    = coeff[COEFF_W-1];
    end

endmodule

// File: rtl/cavlc_coeff_scan.sv
// CAVLC block statistics: TotalCoeff, TotalZeros, TrailingOnes, T1 signs and
// the registered total-zeros table address, held until downstream accepts.
module cavlc_coeff_scan
    import cavlc_pkg::*;
#(
    parameter int unsigned COEFF_W = COEFF_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               coeff_valid,
    output logic               coeff_ready,
    input  logic [COEFF_W-1:0] coeff,
    input  logic               coeff_last,
    output logic               stat_valid,
    input  logic               stat_ready,
    output logic [4:0]         total_coeff,
    output logic [3:0]         total_zeros,
    output logic [1:0]         trailing_ones,
    output logic [2:0]         t1_signs,
    output logic               tz_en,
    output logic [7:0]         tz_addr
);

    state_t     state;
    logic [4:0] cnt;
    logic [4:0] zeros_seen;

    logic       is_zero;
    logic       is_pm1;
    logic       sign;

    logic       accept;
    logic       block_end;
    logic [4:0] tc_nxt;
    logic [3:0] tz_nxt;
    logic [1:0] t1_nxt;
    logic [2:0] sg_nxt;
    logic       tz_en_nxt;
    logic [7:0] tz_addr_nxt;

    cavlc_coeff_classify #(
        .COEFF_W (COEFF_W)
    ) u_classify (
        .coeff   (coeff),
        .is_zero (is_zero),
        .is_pm1  (is_pm1),
        .sign    (sign)
    );

    assign coeff_ready = (state == COLLECT);
    assign stat_valid  = (state == HOLD);

    always_comb begin
        accept    = coeff_valid && (state == COLLECT);
        block_end = coeff_last || (cnt == 5'(MAX_COEFF - 1));

        tc_nxt = total_coeff;
        tz_nxt = total_zeros;
        t1_nxt = trailing_ones;
        sg_nxt = t1_signs;
        if (!is_zero) begin
            tc_nxt = total_coeff + 5'd1;
            // zeros_seen never exceeds 15 when a non-zero can still arrive
            tz_nxt = zeros_seen[3:0];
            if (is_pm1) begin
                t1_nxt = (trailing_ones == 2'd3) ? 2'd3 : trailing_ones + 2'd1;
                sg_nxt = {t1_signs[1:0], sign};
            end else begin
                t1_nxt = '0;
                sg_nxt = '0;
            end
        end

        tz_en_nxt   = (tc_nxt != 5'd0) && (tc_nxt != 5'(MAX_COEFF));
        tz_addr_nxt = tz_en_nxt ? tz_addr_pack(tc_nxt[3:0], tz_nxt) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= COLLECT;
            cnt           <= '0;
            zeros_seen    <= '0;
            total_coeff   <= '0;
            total_zeros   <= '0;
            trailing_ones <= '0;
            t1_signs      <= '0;
            tz_en         <= 1'b0;
            tz_addr       <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        cnt           <= cnt + 5'd1;
                        zeros_seen    <= is_zero ? zeros_seen + 5'd1 : zeros_seen;
                        total_coeff   <= tc_nxt;
                        total_zeros   <= tz_nxt;
                        trailing_ones <= t1_nxt;
                        t1_signs      <= sg_nxt;
                        tz_en         <= tz_en_nxt;
                        tz_addr       <= tz_addr_nxt;
                        if (block_end) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (stat_ready) begin
                        state         <= COLLECT;
                        cnt           <= '0;
                        zeros_seen    <= '0;
                        total_coeff   <= '0;
                        total_zeros   <= '0;
                        trailing_ones <= '0;
                        t1_signs      <= '0;
                        tz_en         <= 1'b0;
                        tz_addr       <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_cavlc_coeff_scan.sv
// Directed self-checking bench for cavlc_coeff_scan.
module tb_cavlc_coeff_scan;

    logic               clk;
    logic               rst_n;
    logic               coeff_valid;
    logic               coeff_ready;
    logic signed [15:0] coeff;
    logic               coeff_last;
    logic               stat_valid;
    logic               stat_ready;
    logic [4:0]         total_coeff;
    logic [3:0]         total_zeros;
    logic [1:0]         trailing_ones;
    logic [2:0]         t1_signs;
    logic               tz_en;
    logic [7:0]         tz_addr;

    int                 errors = 0;
    int                 checks = 0;
    logic signed [15:0] blk [16];

    cavlc_coeff_scan #(
        .COEFF_W (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .coeff_valid   (coeff_valid),
        .coeff_ready   (coeff_ready),
        .coeff         (coeff),
        .coeff_last    (coeff_last),
        .stat_valid    (stat_valid),
        .stat_ready    (stat_ready),
        .total_coeff   (total_coeff),
        .total_zeros   (total_zeros),
        .trailing_ones (trailing_ones),
        .t1_signs      (t1_signs),
        .tz_en         (tz_en),
        .tz_addr       (tz_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one coefficient; it is accepted on the next rising edge once ready.
    task automatic push(input logic signed [15:0] v, input logic last);
        int unsigned waited = 0;
        @(negedge clk);
        while (!coeff_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!coeff_ready) chk("push_ready_timeout", 32'(coeff_ready), 32'd1);
        coeff       = v;
        coeff_last  = last;
        coeff_valid = 1'b1;
        @(posedge clk);
        #1;
        coeff_valid = 1'b0;
        coeff_last  = 1'b0;
    endtask

    task automatic send_block(input int n, input int last_idx);
        for (int i = 0; i < n; i++) push(blk[i], (i == last_idx));
    endtask

    task automatic chk_stats(input string tag, input logic [4:0] tc, input logic [3:0] tz,
                             input logic [1:0] t1, input logic [2:0] sg,
                             input logic en, input logic [7:0] addr);
        chk({tag, "_valid"}, 32'(stat_valid), 32'd1);
        chk({tag, "_ready"}, 32'(coeff_ready), 32'd0);
        chk({tag, "_tc"}, 32'(total_coeff), 32'(tc));
        chk({tag, "_tz"}, 32'(total_zeros), 32'(tz));
        chk({tag, "_t1"}, 32'(trailing_ones), 32'(t1));
        chk({tag, "_sgn"}, 32'(t1_signs), 32'(sg));
        chk({tag, "_en"}, 32'(tz_en), 32'(en));
        chk({tag, "_addr"}, 32'(tz_addr), 32'(addr));
    endtask

    task automatic take_stats(input string tag);
        @(negedge clk);
        stat_ready = 1'b1;
        @(posedge clk);
        #1;
        stat_ready = 1'b0;
        chk({tag, "_bubble_ready"}, 32'(coeff_ready), 32'd1);
        chk({tag, "_bubble_valid"}, 32'(stat_valid), 32'd0);
        chk({tag, "_cleared_tc"}, 32'(total_coeff), 32'd0);
        chk({tag, "_cleared_addr"}, 32'(tz_addr), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        coeff_valid = 1'b0;
        coeff       = '0;
        coeff_last  = 1'b0;
        stat_ready  = 1'b0;
        #12;
        chk("rst_ready", 32'(coeff_ready), 32'd1);
        chk("rst_valid", 32'(stat_valid), 32'd0);
        chk("rst_tc", 32'(total_coeff), 32'd0);
        chk("rst_addr", 32'(tz_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mixed block: tc 5, tz 4, t1 3, signs 100 -> addr 54
        blk = '{16'sd0, 16'sd3, -16'sd1, 16'sd0, 16'sd0, -16'sd1, 16'sd1, 16'sd0,
                16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        send_block(16, -1);
        chk_stats("mixed", 5'd5, 4'd4, 2'd3, 3'b100, 1'b1, 8'h54);
        take_stats("mixed");

        // All zeros
        for (int i = 0; i < 16; i++) blk[i] = 16'sd0;
        send_block(16, -1);
        chk_stats("zeros", 5'd0, 4'd0, 2'd0, 3'b000, 1'b0, 8'h00);
        take_stats("zeros");

        // Sixteen 2s, coeff_last coinciding with the 16-count end
        for (int i = 0; i < 16; i++) blk[i] = 16'sd2;
        send_block(16, 15);
        chk_stats("full", 5'd16, 4'd0, 2'd0, 3'b000, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        chk("full_hold_stays", 32'(stat_valid), 32'd1);
        take_stats("full");

        // Fifteen zeros then 7
        for (int i = 0; i < 15; i++) blk[i] = 16'sd0;
        blk[15] = 16'sd7;
        send_block(16, -1);
        chk_stats("tail7", 5'd1, 4'd15, 2'd0, 3'b000, 1'b1, 8'h1F);
        take_stats("tail7");

        // 15-coefficient AC block ending on coeff_last, then a stalled stat handshake
        for (int i = 0; i < 16; i++) blk[i] = (i < 4) ? 16'sd1 : 16'sd0;
        send_block(15, 14);
        chk_stats("ac", 5'd4, 4'd0, 2'd3, 3'b000, 1'b1, 8'h40);
        coeff       = 16'sd5;
        coeff_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("stall_ready", 32'(coeff_ready), 32'd0);
            chk("stall_valid", 32'(stat_valid), 32'd1);
            chk("stall_tc", 32'(total_coeff), 32'd4);
            chk("stall_t1", 32'(trailing_ones), 32'd3);
            chk("stall_addr", 32'(tz_addr), 32'h40);
        end
        coeff_valid = 1'b0;
        take_stats("ac");

        // Asynchronous reset mid-block, then a clean block
        blk = '{16'sd0, 16'sd3, -16'sd1, 16'sd0, 16'sd0, -16'sd1, 16'sd1, 16'sd0,
                16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        send_block(7, -1);
        chk("partial_tc", 32'(total_coeff), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tc", 32'(total_coeff), 32'd0);
        chk("arst_t1", 32'(trailing_ones), 32'd0);
        chk("arst_sgn", 32'(t1_signs), 32'd0);
        chk("arst_en", 32'(tz_en), 32'd0);
        chk("arst_addr", 32'(tz_addr), 32'd0);
        chk("arst_valid", 32'(stat_valid), 32'd0);
        chk("arst_ready", 32'(coeff_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send_block(16, -1);
        chk_stats("post_rst", 5'd5, 4'd4, 2'd3, 3'b100, 1'b1, 8'h54);
        take_stats("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cavlc_coeff_scan.md
# cavlc_coeff_scan

Upstream statistics stage of the CAVLC encoder. Accepts one residual block's coefficients in zigzag order, one per handshake, and computes TotalCoeff, TotalZeros, TrailingOnes and the trailing-one sign bits. It then presents the packed 8-bit table address consumed by the `Total_Zeros_Enc` lookup, alongside the other statistics, for the downstream coeff_token/level stages.

## Interface
- `COEFF_W`, 16: signed coefficient width.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `coeff_valid`  in  1: coefficient present.
- `coeff_ready`  out  1: stage can accept a coefficient.
- `coeff`  in  COEFF_W: signed coefficient, zigzag order, low frequency first.
- `coeff_last`  in  1: final coefficient of the block (used for 15-coeff AC blocks); ignored if not on a handshake.
- `stat_valid`  out  1: block statistics valid.
- `stat_ready`  in  1: downstream accepts statistics.
- `total_coeff`  out  5: non-zero count, 0..16.
- `total_zeros`  out  4: zeros preceding the last non-zero, 0..15.
- `trailing_ones`  out  2: 0..3.
- `t1_signs`  out  3: bit0 = sign of the highest-frequency trailing one (1 = negative); unused bits are 0.
- `tz_en`  out  1: 1 when 1 <= total_coeff <= 15, meaning total_zeros must be coded.
- `tz_addr`  out  8: {total_coeff[3:0], total_zeros}; 8'h00 when tz_en = 0.

## Operation
- FSM states:
  - COLLECT: coeff_ready = 1, stat_valid = 0.
  - HOLD: coeff_ready = 0, stat_valid = 1, outputs frozen.
- COLLECT -> HOLD on the handshake of a coefficient with coeff_last = 1, or on the 16th accepted coefficient, whichever comes first.
- HOLD -> COLLECT on stat_valid && stat_ready. All accumulators clear in that same cycle.
- Per accepted coefficient, with classification done in the sub-module:
  - zero: zeros_seen++ (5-bit).
  - non-zero: total_coeff++. Latch tz_last <= zeros_seen, so total_zeros = tz_last.
  - ±1 (coeff == 1 or all-ones): trailing_ones = min(t1 + 1, 3); t1_signs <= {t1_signs[1:0], coeff[MSB]}.
  - any other non-zero: trailing_ones <= 0 and t1_signs <= 0.
- The update rule for the accepting cycle includes the final coefficient, so stats are complete when HOLD is entered.
- All-zero block: total_coeff = 0, total_zeros = 0, tz_en = 0.
- total_coeff = 16: tz_en = 0, tz_addr = 0, total_zeros = 0.
- coeff_last on the 16th coefficient is equivalent to the 16-count end; no double transition.

## Timing
- Throughput: 1 coefficient per cycle in COLLECT.
- Latency: stat_valid rises the cycle after the final coefficient handshake.
- One-cycle bubble: coeff_ready returns the cycle after the stat handshake.
- HOLD may last indefinitely; all stat outputs stay stable while stat_valid && !stat_ready.
- stat_valid never drops without a handshake.
- Reset values: state COLLECT, coeff_ready 1, stat_valid 0, all stat outputs and tz_addr 0, internal counters 0.
- Reset mid-block discards the partial block; the first post-reset coefficient is index 0.
- Outputs are registered; tz_addr and tz_en are registered copies, with no combinational path from coeff.

## Structure
- Shared package `cavlc_pkg`:
  - MAX_COEFF = 16.
  - COEFF_W default.
  - State enum {COLLECT, HOLD}.
  - TZ_ADDR_W = 8.
  - Function packing {tc[3:0], tz} into the total-zeros address; also used by `Total_Zeros_Enc` callers.
- Sub-module `cavlc_coeff_classify`: combinational; coeff -> is_zero, is_pm1, sign.

## Test plan
- Zigzag 0,3,-1,0,0,-1,1,0,1,0,0,0,0,0,0,0 -> total_coeff 5, total_zeros 4, trailing_ones 3, t1_signs 3'b100, tz_en 1, tz_addr 8'h54.
- 16 zeros -> total_coeff 0, total_zeros 0, trailing_ones 0, tz_en 0, tz_addr 8'h00.
- Sixteen coefficients of value 2 -> total_coeff 16, total_zeros 0, trailing_ones 0, tz_en 0, tz_addr 8'h00.
- Fifteen zeros then 7 at index 15 -> total_coeff 1, total_zeros 15, trailing_ones 0, tz_addr 8'h1F.
- AC block 1,1,1,1 then zeros, coeff_last on the 15th, with stat_ready held low 5 cycles -> total_coeff 4, total_zeros 0, trailing_ones 3, tz_addr 8'h40. Outputs stay stable and coeff_ready stays 0 during the stall; coeff_ready = 1 the cycle after the handshake.
- Assert rst_n low after 7 coefficients -> all outputs 0 asynchronously. The next full block, using the first vector, yields 8'h54.
